enc16to4_seq: RTL and testbench

Sequential 16-to-4 encoder; inverse direction of the team's 4-to-16 enable decoder.
Accepts a 16-bit multi-hot word (bit order [0:15], bit i <-> code i) on a valid/ready handshake, then emits the 4-bit index of every set bit, one per accepted output beat, in priority order.
Used to turn decoder-style line vectors (interrupt/request lines) back into binary codes; also a round-trip checker for the 4-to-16 decoder.

---
 rtl/enc16to4_seq_pkg.sv | 23 ++
 rtl/enc16to4_seq_prio_enc16.sv | 33 +++
 rtl/enc16to4_seq.sv | 127 ++++++++++++
 tb/tb_enc16to4_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc16to4_seq_pkg.sv
// Shared definitions for the sequential 16-to-4 encoder: FSM states, widths
// and the line-vector to bit-vector helper.
package enc16to4_seq_pkg;

   localparam int N_LINES = 16;
   localparam int CODE_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // Line vectors are declared [0:15] so that bit i means code i; internally a
   // conventional [15:0] vector with the same bit-to-code mapping is used.
   function automatic logic [N_LINES-1:0] lines_to_vec(input logic [0:N_LINES-1] lines);
      logic [N_LINES-1:0] v;
      for (int i = 0; i < N_LINES; i++) begin
         v[i] = lines[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/enc16to4_seq_prio_enc16.sv
// Combinational 16-bit priority encoder: index of the winning set bit, its
// one-hot mask, and flags for "any bit set" and "exactly one bit set".
module prio_enc16
   import enc16to4_seq_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic [N_LINES-1:0] vec_i,
   output logic [CODE_W-1:0]  idx_o,
   output logic               any_o,
   output logic [N_LINES-1:0] onehot_o,
   output logic               single_o
);

   always_comb begin
      idx_o = '0;
      // Scan toward the winning end so that the last hit is the priority one.
      if (LSB_FIRST) begin
         for (int i = N_LINES - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < N_LINES; i++) begin
            if (vec_i[i]) idx_o = CODE_W'(i);
         end
      end
   end

   assign any_o    = |vec_i;
   assign onehot_o = any_o ? (N_LINES'(1) << idx_o) : '0;
   assign single_o = any_o && ((vec_i & (vec_i - N_LINES'(1))) == '0);

endmodule

// File: rtl/enc16to4_seq.sv
// Sequential 16-to-4 encoder: captures a multi-hot line word on a valid/ready
// handshake and emits the code of every set line, one per accepted beat.
module enc16to4_seq
   import enc16to4_seq_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [0:N_LINES-1]  D,
   input  logic                En,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CODE_W-1:0]   A,
   output logic                last,
   output logic                none
);

   state_e               state_q, state_d;
   logic [N_LINES-1:0]   pending_q, pending_d;
   logic [N_LINES-1:0]   mask_q, mask_d;
   logic [CODE_W-1:0]    a_q, a_d;
   logic                 last_q, last_d;
   logic                 none_q, none_d;
   logic                 vld_q, vld_d;

   logic [N_LINES-1:0]   scan_vec;
   logic [CODE_W-1:0]    enc_idx;
   logic                 enc_any;
   logic [N_LINES-1:0]   enc_onehot;
   logic                 enc_single;
   logic                 capture;
   logic                 accept;

   prio_enc16 #(
      .LSB_FIRST (LSB_FIRST)
   ) u_prio (
      .vec_i    (scan_vec),
      .idx_o    (enc_idx),
      .any_o    (enc_any),
      .onehot_o (enc_onehot),
      .single_o (enc_single)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_EMIT;
         ST_EMIT: if (vld_q && out_ready && last_q) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The encoder looks at the word the next beat will come from, so the
   // beat outputs can be registered without an extra cycle of latency.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      capture   = in_ready && in_valid;
      accept    = vld_q && out_ready;
      scan_vec  = pending_q;
      pending_d = pending_q;
      mask_d    = mask_q;
      a_d       = a_q;
      last_d    = last_q;
      none_d    = none_q;
      vld_d     = vld_q;
      if (capture) begin
         scan_vec  = En ? lines_to_vec(D) : '0;
         pending_d = scan_vec;
         mask_d    = enc_onehot;
         a_d       = enc_any ? enc_idx : '0;
         last_d    = enc_any ? enc_single : 1'b1;
         none_d    = !enc_any;
         vld_d     = 1'b1;
      end else if (accept) begin
         if (last_q) begin
            pending_d = '0;
            mask_d    = '0;
            a_d       = '0;
            last_d    = 1'b0;
            none_d    = 1'b0;
            vld_d     = 1'b0;
         end else begin
            scan_vec  = pending_q & ~mask_q;
            pending_d = scan_vec;
            mask_d    = enc_onehot;
            a_d       = enc_idx;
            last_d    = enc_single;
            none_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         mask_q    <= '0;
         a_q       <= '0;
         last_q    <= 1'b0;
         none_q    <= 1'b0;
         vld_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         a_q       <= a_d;
         last_q    <= last_d;
         none_q    <= none_d;
         vld_q     <= vld_d;
      end
   end

   assign out_valid = vld_q;
   assign A         = a_q;
   assign last      = last_q;
   assign none      = none_q;

endmodule

// File: tb/tb_enc16to4_seq.sv
// Scoreboard bench for enc16to4_seq: one LSB-first and one MSB-first instance
// share the same stimulus; expected beats are queued at capture time.
module tb_enc16to4_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        En;
   logic [0:15] D;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, last, none;
   logic [3:0]  A;
   logic        in_ready_m, out_valid_m, last_m, none_m;
   logic [3:0]  A_m;

   typedef struct {
      logic [3:0] a_lo;
      logic [3:0] a_hi;
      logic       last;
      logic       none;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_err    = 0;
   int acc_cnt  = 0;
   int rdy_mode = 0;
   int pc       = 0;
   logic [3:0] ptn = 4'b1001;

   enc16to4_seq #(.LSB_FIRST(1'b1)) u_lsb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .En        (En),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .last      (last),
      .none      (none)
   );

   enc16to4_seq #(.LSB_FIRST(1'b0)) u_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_m),
      .D         (D),
      .En        (En),
      .out_valid (out_valid_m),
      .out_ready (out_ready),
      .A         (A_m),
      .last      (last_m),
      .none      (none_m)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [0:15] d, input logic en);
      logic [3:0] lo[16];
      logic [3:0] hi[16];
      int n;
      exp_t e;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (en && d[i]) begin
            lo[n] = 4'(i);
            n++;
         end
      end
      for (int i = 0; i < n; i++) hi[i] = lo[n-1-i];
      if (n == 0) begin
         e.a_lo = 4'd0; e.a_hi = 4'd0; e.last = 1'b1; e.none = 1'b1;
         q.push_back(e);
      end else begin
         for (int k = 0; k < n; k++) begin
            e.a_lo = lo[k]; e.a_hi = hi[k]; e.last = (k == n - 1); e.none = 1'b0;
            q.push_back(e);
         end
      end
   endtask

   function automatic logic [0:15] dec4to16(input logic [3:0] a, input logic en);
      logic [0:15] v;
      v = '0;
      if (en) v[a] = 1'b1;
      return v;
   endfunction

   // out_ready pattern generator: 0 = always ready, 1 = 1,0,0,1 cycle, 2 = random
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = ptn[pc];
            pc = (pc + 1) % 4;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Output monitor: every presented beat must match the queue head; pop on accept.
   always @(negedge clk) begin
      if (rst_n && (out_valid || out_valid_m)) begin
         chk("valid_pair", 32'(out_valid_m), 32'(out_valid));
         chk("in_ready_in_emit", 32'(in_ready | in_ready_m), 32'(0));
         chk("beat_expected", 32'(q.size() != 0), 32'(1));
         if (q.size() != 0) begin
            mon_e = q[0];
            chk("A_lsb_first", 32'(A), 32'(mon_e.a_lo));
            chk("A_msb_first", 32'(A_m), 32'(mon_e.a_hi));
            chk("last_lsb", 32'(last), 32'(mon_e.last));
            chk("last_msb", 32'(last_m), 32'(mon_e.last));
            chk("none_lsb", 32'(none), 32'(mon_e.none));
            chk("none_msb", 32'(none_m), 32'(mon_e.none));
            if (out_ready) begin
               void'(q.pop_front());
               acc_cnt++;
            end
         end
      end
   end

   task automatic send_word(input logic [0:15] d, input logic en);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      D = d; En = en; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'(1));
      push_exp(d, en);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int exp_cyc);
      int n;
      @(negedge clk);
      n = 1;
      chk("first_beat_latency", 32'(out_valid), 32'(1));
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(in_ready), 32'(1));
      chk("queue_drained", 32'(q.size()), 32'(0));
      if (exp_cyc >= 0) chk("word_cycles", 32'(n), 32'(exp_cyc));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int t;
      logic [0:15] w;
      rst_n = 1'b0; in_valid = 1'b0; D = '0; En = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid | out_valid_m), 32'(0));
      chk("rst_A", 32'(A), 32'(0));
      chk("rst_last", 32'(last), 32'(0));
      chk("rst_none", 32'(none), 32'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset in the middle of an all-ones scan
      base = acc_cnt;
      send_word(16'hFFFF, 1'b1);
      t = 0;
      while (acc_cnt < base + 3 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("three_beats_before_reset", 32'(acc_cnt >= base + 3), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid | out_valid_m), 32'(0));
      chk("async_rst_in_ready", 32'(in_ready & in_ready_m), 32'(1));
      chk("async_rst_A", 32'(A), 32'(0));
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_old_beats", 32'(out_valid | out_valid_m), 32'(0));

      // Full all-ones word
      send_word(16'hFFFF, 1'b1);
      wait_idle(17);

      // Disabled word masks everything
      send_word(16'hA5A5, 1'b0);
      wait_idle(2);

      // One-hot bit 9
      w = '0; w[9] = 1'b1;
      send_word(w, 1'b1);
      wait_idle(2);

      // Bits 1, 4, 14
      w = '0; w[1] = 1'b1; w[4] = 1'b1; w[14] = 1'b1;
      send_word(w, 1'b1);
      wait_idle(4);

      // Same word under backpressure, D scrambled during the scan
      rdy_mode = 1;
      base = acc_cnt;
      send_word(w, 1'b1);
      D = 16'hFFFF; En = 1'b1;
      @(posedge clk);
      #1 D = 16'h5A5A; En = 1'b0;
      wait_idle(-1);
      chk("stall_accepted_beats", 32'(acc_cnt - base), 32'(3));
      rdy_mode = 0;

      // Round trip through a 4-to-16 decoder model
      for (int a = 0; a < 16; a++) begin
         send_word(dec4to16(4'(a), 1'b1), 1'b1);
         wait_idle(2);
      end
      for (int a = 0; a < 4; a++) begin
         send_word(dec4to16(4'(a * 5), 1'b0), 1'b0);
         wait_idle(2);
      end

      // Random words with random backpressure
      rdy_mode = 2;
      for (int k = 0; k < 20; k++) begin
         w = 16'($urandom & $urandom);
         send_word(w, 1'($urandom_range(0, 7) != 0));
         wait_idle(-1);
      end
      rdy_mode = 0;

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
